// File: rtl/syn_gpu_div_arb.sv
// Round-robin arbiter letting N_REQ requesters share one tagged divider.
// Issues one request at a time and waits for a matching tag or a timeout.
module syn_gpu_div_arb #(
  parameter int N_REQ = 4,
  parameter int MID_W = 4,
  parameter int TMO_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*32-1:0]   req_data,
  output logic [N_REQ-1:0]      req_rdy,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  err_tmo,
  output logic [MID_W-1:0]      div_req_mid,
  output logic [31:0]           div_req_data,
  input  logic                  div_busy,
  input  logic [MID_W-1:0]      div_rsp_mid,
  input  logic [31:0]           div_rsp_data
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [MID_W-1:0] MID_IDLE = '0;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [IDX_W-1:0] last_grant;
  logic [31:0]      lat_data;
  logic [TMO_W-1:0] cnt;

  logic [31:0]      req_word [N_REQ];
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             gnt_found;
  logic             grant_ok;
  logic             grant;
  logic [MID_W-1:0] own_tag;
  logic             rsp_match;
  logic             tmo_hit;

  for (genvar g = 0; g < N_REQ; g++) begin : g_word
    assign req_word[g] = req_data[g*32 +: 32];
  end

  // Search starts one past the previous winner so every requester is served in turn.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + 1 + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // The owner is always the last winner, so its tag is derived rather than stored.
  assign own_tag   = MID_W'(last_grant) + MID_W'(1);
  assign grant_ok  = !rst && (state == S_IDLE) && !div_busy && !(|rsp_valid);
  assign grant     = grant_ok && gnt_found;
  assign req_rdy   = grant ? (ONE << gnt_idx) : '0;
  assign rsp_match = (state == S_WAIT) && (div_rsp_mid == own_tag);
  assign tmo_hit   = (state == S_WAIT) && (cnt == '1) && !rsp_match;
  assign err_tmo   = tmo_hit;

  assign div_req_mid  = (state == S_ISSUE) ? own_tag : MID_IDLE;
  assign div_req_data = lat_data;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      lat_data   <= '0;
      cnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            state      <= S_ISSUE;
            last_grant <= gnt_idx;
            lat_data   <= req_word[gnt_idx];
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          if (rsp_match) begin
            rsp_data  <= div_rsp_data;
            rsp_valid <= ONE << last_grant;
            state     <= S_IDLE;
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + TMO_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_gpu_div_arb.sv
// Directed bench for syn_gpu_div_arb: single request, fairness, busy hold-off,
// wrong tag, timeout and reset during WAIT, with hand-computed expectations.
module tb_syn_gpu_div_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_rdy;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic         err_tmo;
  logic [3:0]   div_req_mid;
  logic [31:0]  div_req_data;
  logic         div_busy;
  logic [3:0]   div_rsp_mid;
  logic [31:0]  div_rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  syn_gpu_div_arb #(.N_REQ(4), .MID_W(4), .TMO_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_rdy      (req_rdy),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .err_tmo      (err_tmo),
    .div_req_mid  (div_req_mid),
    .div_req_data (div_req_data),
    .div_busy     (div_busy),
    .div_rsp_mid  (div_rsp_mid),
    .div_rsp_data (div_rsp_data)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    div_busy     = 1'b0;
    div_rsp_mid  = '0;
    div_rsp_data = '0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = '0;
    div_busy = 1'b0;
    div_rsp_mid = '0;
    div_rsp_data = '0;
    #1;
    n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_req_rdy: got %b expected %b", req_rdy, 4'b0000); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected %b", rsp_valid, 4'b0000); end
    n_checks++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL reset_err_tmo: got %b expected 0", err_tmo); end
    n_checks++; if (div_req_mid !== 4'h0) begin n_fail++; $display("FAIL reset_div_req_mid: got %h expected 0", div_req_mid); end
    n_checks++; if (div_req_data !== 32'h0) begin n_fail++; $display("FAIL reset_div_req_data: got %h expected 0", div_req_data); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_data[31:0] = 32'h0064_0007;
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL single_rdy: got %b expected %b", req_rdy, 4'b0001); end
    step();
    req_valid = 4'b0000;
    #1;
    n_checks++; if (div_req_mid !== 4'h1) begin n_fail++; $display("FAIL single_issue_mid: got %h expected %h", div_req_mid, 4'h1); end
    n_checks++; if (div_req_data !== 32'h0064_0007) begin n_fail++; $display("FAIL single_issue_data: got %h expected %h", div_req_data, 32'h0064_0007); end
    step();
    n_checks++; if (div_req_mid !== 4'h0) begin n_fail++; $display("FAIL single_wait_mid: got %h expected 0", div_req_mid); end
    n_checks++; if (div_req_data !== 32'h0064_0007) begin n_fail++; $display("FAIL single_wait_data_hold: got %h expected %h", div_req_data, 32'h0064_0007); end
    div_rsp_mid = 4'h1;
    div_rsp_data = 32'h000E_0002;
    step();
    div_rsp_mid = 4'h0;
    div_rsp_data = 32'h0;
    #1;
    n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected %b", rsp_valid, 4'b0001); end
    n_checks++; if (rsp_data !== 32'h000E_0002) begin n_fail++; $display("FAIL single_rsp_data: got %h expected %h", rsp_data, 32'h000E_0002); end
    step();
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_pulse_len: got %b expected %b", rsp_valid, 4'b0000); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_oh;
    logic [3:0] tag;
    logic [31:0] word;
    do_reset();
    req_data = {32'hD000_0004, 32'hC000_0003, 32'hB000_0002, 32'hA000_0001};
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_oh = 4'b0001 << (i % 4);
      tag    = 4'((i % 4) + 1);
      word   = {4'((i % 4) + 10), 12'h000, 16'((i % 4) + 1)};
      for (int c = 0; c < 20 && req_rdy == 4'b0000; c++) step();
      n_checks++; if (req_rdy !== exp_oh) begin n_fail++; $display("FAIL fair_grant_%0d: got %b expected %b", i, req_rdy, exp_oh); end
      step();
      n_checks++; if (div_req_mid !== tag) begin n_fail++; $display("FAIL fair_issue_mid_%0d: got %h expected %h", i, div_req_mid, tag); end
      n_checks++; if (div_req_data !== word) begin n_fail++; $display("FAIL fair_issue_data_%0d: got %h expected %h", i, div_req_data, word); end
      n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL fair_one_outstanding_issue_%0d: got %b expected 0000", i, req_rdy); end
      step();
      div_rsp_mid = tag;
      div_rsp_data = 32'(i);
      #1;
      n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL fair_one_outstanding_wait_%0d: got %b expected 0000", i, req_rdy); end
      step();
      div_rsp_mid = 4'h0;
      #1;
      n_checks++; if (rsp_valid !== exp_oh) begin n_fail++; $display("FAIL fair_rsp_valid_%0d: got %b expected %b", i, rsp_valid, exp_oh); end
      n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL fair_no_grant_with_rsp_%0d: got %b expected 0000", i, req_rdy); end
      step();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_busy();
    do_reset();
    div_busy = 1'b1;
    req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL busy_hold_%0d: got %b expected 0000", c, req_rdy); end
      step();
    end
    req_valid = 4'b0010;
    div_busy = 1'b0;
    #1;
    n_checks++; if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL busy_release_grant: got %b expected %b", req_rdy, 4'b0010); end
  endtask

  task automatic test_wrong_tag();
    do_reset();
    req_data[63:32] = 32'h0050_0005;
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL tag_grant: got %b expected %b", req_rdy, 4'b0010); end
    step();
    req_valid = 4'b0000;
    #1;
    n_checks++; if (div_req_mid !== 4'h2) begin n_fail++; $display("FAIL tag_issue_mid: got %h expected %h", div_req_mid, 4'h2); end
    step();
    div_rsp_mid = 4'h3;
    div_rsp_data = 32'hDEAD_BEEF;
    step();
    div_rsp_mid = 4'h0;
    #1;
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL tag_wrong_ignored: got %b expected 0000", rsp_valid); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL tag_wrong_data: got %h expected 0", rsp_data); end
    div_rsp_mid = 4'h2;
    div_rsp_data = 32'h0010_0000;
    step();
    div_rsp_mid = 4'h0;
    #1;
    n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL tag_right_rsp: got %b expected %b", rsp_valid, 4'b0010); end
    n_checks++; if (rsp_data !== 32'h0010_0000) begin n_fail++; $display("FAIL tag_right_data: got %h expected %h", rsp_data, 32'h0010_0000); end
  endtask

  task automatic test_timeout();
    do_reset();
    req_data[31:0] = 32'h0001_0001;
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL tmo_grant: got %b expected %b", req_rdy, 4'b0001); end
    step();
    req_valid = 4'b0000;
    step();
    // First WAIT cycle is k = 0; the pulse lands on k = 15.
    for (int k = 0; k < 15; k++) begin
      #1;
      n_checks++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_early_%0d: got %b expected 0", k, err_tmo); end
      step();
    end
    req_valid = 4'b0100;
    #1;
    n_checks++; if (err_tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got %b expected 1", err_tmo); end
    n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL tmo_no_grant_in_wait: got %b expected 0000", req_rdy); end
    step();
    n_checks++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_len: got %b expected 0", err_tmo); end
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL tmo_no_rsp: got %b expected 0000", rsp_valid); end
    n_checks++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL tmo_next_grant: got %b expected %b", req_rdy, 4'b0100); end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req_data[31:0] = 32'h1234_0002;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    step();
    rst = 1'b1;
    #1;
    n_checks++; if (div_req_data !== 32'h0) begin n_fail++; $display("FAIL rstw_div_req_data: got %h expected 0", div_req_data); end
    step();
    rst = 1'b0;
    div_rsp_mid = 4'h1;
    div_rsp_data = 32'h0000_0042;
    step();
    div_rsp_mid = 4'h0;
    #1;
    n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rstw_no_rsp: got %b expected 0000", rsp_valid); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL rstw_rsp_data: got %h expected 0", rsp_data); end
    n_checks++; if (div_req_mid !== 4'h0) begin n_fail++; $display("FAIL rstw_div_req_mid: got %h expected 0", div_req_mid); end
    n_checks++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL rstw_err_tmo: got %b expected 0", err_tmo); end
    n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL rstw_req_rdy: got %b expected 0000", req_rdy); end
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_rdy !== 4'b0001 << 1) begin n_fail++; $display("FAIL rstw_first_grant_rr: got %b expected %b", req_rdy, 4'b0010); end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_busy();
    test_wrong_tag();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
